// File: rtl/ads_seq_ctrl.sv
// ads_seq_ctrl: ADS1115 transaction sequencer.
// Configures the ADC for continuous conversion, points at the conversion
// register, then reads a 16-bit sample every CONV_WAIT cycles. Talks to an I2C
// byte engine with one command outstanding at a time.
// Optional: define ADS_SEQ_RSP_TIMEOUT_EN to add a response watchdog
// (parameter RSP_TIMEOUT); expiry is handled like a NACK.
module ads_seq_ctrl #(
  parameter logic [6:0] I2C_ADDR  = 7'h48,
  parameter logic [2:0] PGA       = 3'b001,
  parameter logic [7:0] CFG_LO    = 8'h83,
  parameter int         CONV_WAIT = 400000,
  parameter int         BACKOFF   = 50000
`ifdef ADS_SEQ_RSP_TIMEOUT_EN
  , parameter int       RSP_TIMEOUT = 65535
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  cfg_mux,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_data,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  input  logic [7:0]  rsp_data,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        err,
  output logic [7:0]  err_cnt
);
  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_RDACK  = 3'd2;
  localparam logic [2:0] OP_RDNACK = 3'd3;
  localparam logic [2:0] OP_STOP   = 3'd4;

  localparam int MAXC = (CONV_WAIT > BACKOFF) ? CONV_WAIT : BACKOFF;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(CONV_WAIT - 1);
  localparam logic [CW-1:0] BOFF_LAST = CW'(BACKOFF - 1);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_PTR, S_WAIT, S_RD, S_ERR, S_BACKOFF} state_t;
  state_t state, state_n;

  logic [2:0]    step;   // command index within the current transaction
  logic          pend;   // a command was accepted and its response is owed
  logic [CW-1:0] cnt;    // WAIT / BACKOFF dwell counter
  logic [2:0]    mux_l;  // mux captured when CFG is entered
  logic [7:0]    msb, lsb;
  logic [2:0]    op;
  logic [7:0]    wdata;
  logic          rsp, fail, done, tmo;

`ifdef ADS_SEQ_RSP_TIMEOUT_EN
  localparam int TW = $clog2(RSP_TIMEOUT + 1);
  logic [TW-1:0] wdog;
  assign tmo = pend && !rsp_valid && (wdog == TW'(RSP_TIMEOUT - 1));

  // Watchdog: restarts on every accepted command, runs while a response is owed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     wdog <= '0;
    else if (cmd_valid && cmd_ready) wdog <= '0;
    else if (pend)                  wdog <= wdog + TW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  assign rsp       = pend && rsp_valid;
  assign fail      = (rsp && op == OP_WRITE && rsp_nack) || tmo;
  assign done      = rsp && op == OP_STOP;
  assign cmd_valid = (state == S_CFG || state == S_PTR || state == S_RD || state == S_ERR) && !pend;
  assign cmd_op    = op;
  assign cmd_data  = (op == OP_WRITE) ? wdata : 8'h00;
  assign busy      = (state != S_IDLE);

  // Command table: op/byte for the current transaction step
  always_comb begin
    op    = OP_START;
    wdata = 8'h00;
    case (state)
      S_CFG: begin
        case (step)
          3'd0:    op = OP_START;
          3'd1:    begin op = OP_WRITE; wdata = {I2C_ADDR, 1'b0}; end
          3'd2:    begin op = OP_WRITE; wdata = 8'h01; end
          3'd3:    begin op = OP_WRITE; wdata = {1'b1, mux_l, PGA, 1'b0}; end
          3'd4:    begin op = OP_WRITE; wdata = CFG_LO; end
          default: op = OP_STOP;
        endcase
      end
      S_PTR: begin
        case (step)
          3'd0:    op = OP_START;
          3'd1:    begin op = OP_WRITE; wdata = {I2C_ADDR, 1'b0}; end
          3'd2:    begin op = OP_WRITE; wdata = 8'h00; end
          default: op = OP_STOP;
        endcase
      end
      S_RD: begin
        case (step)
          3'd0:    op = OP_START;
          3'd1:    begin op = OP_WRITE; wdata = {I2C_ADDR, 1'b1}; end
          3'd2:    op = OP_RDACK;
          3'd3:    op = OP_RDNACK;
          default: op = OP_STOP;
        endcase
      end
      S_ERR:   op = OP_STOP;
      default: op = OP_START;
    endcase
  end

  // Next state: transactions run to their STOP; enable only gates new ones
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (enable) state_n = S_CFG;
      S_CFG:     if (fail) state_n = S_ERR; else if (done) state_n = enable ? S_PTR : S_IDLE;
      S_PTR:     if (fail) state_n = S_ERR; else if (done) state_n = enable ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!enable)                 state_n = S_IDLE;
        else if (cfg_mux != mux_l)   state_n = S_CFG;
        else if (cnt == WAIT_LAST)   state_n = S_RD;
      end
      S_RD:      if (fail) state_n = S_ERR; else if (done) state_n = enable ? S_WAIT : S_IDLE;
      // A STOP that times out in ERR skips straight to the backoff
      S_ERR:     if (fail || done) state_n = S_BACKOFF;
      S_BACKOFF: if (cnt == BOFF_LAST) state_n = enable ? S_CFG : S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Step/handshake tracking, dwell counter, read capture and error bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step         <= '0;
      pend         <= 1'b0;
      cnt          <= '0;
      mux_l        <= '0;
      msb          <= '0;
      lsb          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      err          <= 1'b0;
      err_cnt      <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (state_n != state) begin
        step <= '0;
        pend <= 1'b0;
        cnt  <= '0;
      end else begin
        if (cmd_valid && cmd_ready) pend <= 1'b1;
        else if (rsp) begin
          pend <= 1'b0;
          step <= step + 3'd1;
        end
        if (state == S_WAIT || state == S_BACKOFF) cnt <= cnt + CW'(1);
      end
      if (state_n == S_CFG && state != S_CFG) mux_l <= cfg_mux;
      if (rsp && state == S_RD && op == OP_RDACK)  msb <= rsp_data;
      if (rsp && state == S_RD && op == OP_RDNACK) lsb <= rsp_data;
      if (done && state == S_RD) begin
        sample       <= {msb, lsb};
        sample_valid <= 1'b1;
        err          <= 1'b0;
      end
      if (fail) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_ads_seq_ctrl.sv
// tb_ads_seq_ctrl: the bench plays the I2C byte engine and walks the expected
// transaction stream (CFG / PTR / RD / error recovery) at transaction level.
module tb_ads_seq_ctrl;
  localparam int CONV_WAIT = 40;
  localparam int BACKOFF   = 20;
  localparam logic [2:0] OP_START = 3'd0, OP_WRITE = 3'd1, OP_RDACK = 3'd2,
                         OP_RDNACK = 3'd3, OP_STOP = 3'd4;
  localparam logic [6:0] ADDR = 7'h48;
  localparam int K_CFG = 0, K_PTR = 1, K_RD = 2;

  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [2:0]  cfg_mux = 3'b000;
  logic        cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_nack = 1'b0;
  logic [7:0]  rsp_data = 8'h00;
  logic        cmd_valid, sample_valid, busy, err;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data, err_cnt;
  logic [15:0] sample;

  ads_seq_ctrl #(.CONV_WAIT(CONV_WAIT), .BACKOFF(BACKOFF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_mux(cfg_mux),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_data(rsp_data),
    .sample(sample), .sample_valid(sample_valid), .busy(busy), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  int first_cyc, rsp_cyc;
  int m_err_cnt = 0;
  logic [15:0] m_sample = 16'h0000;
  logic [2:0]  m_mux;
  logic [10:0] seq [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected command streams, straight from the ADS1115 register map
  task automatic set_cfg(input logic [2:0] mux);
    seq[0] = {OP_START, 8'h00};
    seq[1] = {OP_WRITE, ADDR, 1'b0};
    seq[2] = {OP_WRITE, 8'h01};
    seq[3] = {OP_WRITE, 1'b1, mux, 3'b001, 1'b0};
    seq[4] = {OP_WRITE, 8'h83};
    seq[5] = {OP_STOP, 8'h00};
  endtask
  task automatic set_ptr();
    seq[0] = {OP_START, 8'h00};
    seq[1] = {OP_WRITE, ADDR, 1'b0};
    seq[2] = {OP_WRITE, 8'h00};
    seq[3] = {OP_STOP, 8'h00};
  endtask
  task automatic set_rd();
    seq[0] = {OP_START, 8'h00};
    seq[1] = {OP_WRITE, ADDR, 1'b1};
    seq[2] = {OP_RDACK, 8'h00};
    seq[3] = {OP_RDNACK, 8'h00};
    seq[4] = {OP_STOP, 8'h00};
  endtask

  // Engine accept side: wait for a command, stall `hold` cycles, then accept
  task automatic get_cmd(input int hold, output logic [2:0] op, output logic [7:0] d);
    int t = 0;
    int bad = 0;
    cmd_ready = 1'b0;
    while (cmd_valid !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    op = cmd_op; d = cmd_data; first_cyc = cyc;
    if (cmd_valid !== 1'b1) begin chk("cmd_wait_bound", 32'(cmd_valid), 32'd1); return; end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_op !== op || cmd_data !== d) bad++;
    end
    if (hold > 0) chk("hold_stable", 32'(bad), 32'd0);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("valid_drop", 32'(cmd_valid), 32'd0);
  endtask

  // Engine response side: one-cycle rsp_valid pulse after `dly` cycles
  task automatic respond(input int dly, input logic nack, input logic [7:0] d);
    int bad = 0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) bad++;
    end
    rsp_valid = 1'b1; rsp_nack = nack; rsp_data = d; rsp_cyc = cyc;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
    chk("one_outstanding", 32'(bad), 32'd0);
  endtask

  // One transaction against seq[]; a NACK at nack_at diverts to the error STOP
  task automatic run_txn(input string tag, input int n, input int nack_at, input logic [15:0] rd,
                         input int exp_start, input int hold_at, input int drop_at,
                         output logic nacked, output int t_end);
    logic [2:0] op;
    logic [7:0] d, rb;
    nacked = 1'b0; t_end = 0;
    for (int i = 0; i < n; i++) begin
      get_cmd((i == hold_at) ? 10 : int'($urandom_range(0, 2)), op, d);
      chk($sformatf("%s_cmd%0d", tag, i), 32'({op, d}), 32'(seq[i]));
      if (i == 0 && exp_start >= 0) chk($sformatf("%s_start_cyc", tag), 32'(first_cyc), 32'(exp_start));
      if (i == drop_at) enable = 1'b0;
      rb = (op == OP_RDACK) ? rd[15:8] : (op == OP_RDNACK) ? rd[7:0] : 8'h00;
      respond(int'($urandom_range(0, 3)), (i == nack_at), rb);
      t_end = rsp_cyc;
      if (i == nack_at) begin
        nacked = 1'b1;
        m_err_cnt = (m_err_cnt == 255) ? 255 : m_err_cnt + 1;
        chk("nack_err", 32'(err), 32'd1);
        chk("nack_err_cnt", 32'(err_cnt), 32'(m_err_cnt));
        get_cmd(0, op, d);
        chk("err_stop", 32'({op, d}), 32'({OP_STOP, 8'h00}));
        chk("err_stop_cyc", 32'(first_cyc), 32'(t_end + 1));
        respond(int'($urandom_range(0, 3)), 1'b0, 8'h00);
        t_end = rsp_cyc;
        break;
      end
    end
  endtask

  task automatic rd_done(input logic [15:0] v);
    m_sample = v;
    chk("sample_valid_pulse", 32'(sample_valid), 32'd1);
    chk("sample", 32'(sample), 32'(v));
    chk("err_clear", 32'(err), 32'd0);
    @(negedge clk);
    chk("sample_valid_one", 32'(sample_valid), 32'd0);
  endtask

  // Change the mux partway through WAIT; no read may start before the change
  task automatic mux_change(output int ex);
    int bad = 0;
    int k = int'($urandom_range(0, 20));
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) bad++;
    end
    chk("wait_quiet", 32'(bad), 32'd0);
    m_mux = m_mux ^ 3'($urandom_range(1, 7));
    cfg_mux = m_mux;
    ex = cyc + 1;
  endtask

  initial begin
    int t, ex, nk, bad;
    logic nacked;
    logic [15:0] rr;

    #1 reset = 1'b0;
    enable = 1'b1; cfg_mux = 3'b100; m_mux = 3'b100;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({cmd_valid, cmd_op, cmd_data, sample_valid, busy, err, err_cnt}), 32'd0);
    chk("reset_sample", 32'(sample), 32'd0);
    reset = 1'b1;

    // Bring-up: CFG (with a 10-cycle stall on the address write), PTR, first read
    set_cfg(m_mux);
    run_txn("cfg", 6, -1, 16'h0, -1, 1, -1, nacked, t);
    chk("busy", 32'(busy), 32'd1);
    set_ptr();
    run_txn("ptr", 4, -1, 16'h0, t + 1, -1, -1, nacked, t);
    set_rd();
    run_txn("rd", 5, -1, 16'h1234, t + CONV_WAIT + 1, -1, -1, nacked, t);
    rd_done(16'h1234);

    // Mux change in WAIT -> CFG with new config-hi, NACK on the address write
    mux_change(ex);
    set_cfg(m_mux);
    run_txn("cfg_nack", 6, 1, 16'h0, ex, -1, -1, nacked, t);
    chk("sample_hold", 32'(sample), 32'(m_sample));
    run_txn("cfg_retry", 6, -1, 16'h0, t + BACKOFF + 1, -1, -1, nacked, t);
    chk("err_sticky", 32'(err), 32'd1);
    set_ptr();
    run_txn("ptr2", 4, -1, 16'h0, t + 1, -1, -1, nacked, t);
    rr = 16'($urandom);
    set_rd();
    run_txn("rd2", 5, -1, rr, t + CONV_WAIT + 1, -1, -1, nacked, t);
    rd_done(rr);

    // enable drops right after the read START: read completes, then idle
    rr = 16'($urandom);
    run_txn("rd_dis", 5, -1, rr, t + CONV_WAIT + 1, -1, 0, nacked, t);
    rd_done(rr);
    chk("idle_busy", 32'(busy), 32'd0);
    rsp_valid = 1'b1; rsp_nack = 1'b1;  // stray response with nothing outstanding
    @(negedge clk);
    rsp_valid = 1'b0; rsp_nack = 1'b0;
    bad = 0;
    repeat (CONV_WAIT + 5) begin @(negedge clk); if (cmd_valid !== 1'b0) bad++; end
    chk("idle_quiet", 32'(bad), 32'd0);
    chk("stray_rsp_err_cnt", 32'(err_cnt), 32'(m_err_cnt));
    enable = 1'b1;
    ex = cyc + 1;
    set_cfg(m_mux);
    run_txn("cfg_reen", 6, -1, 16'h0, ex, -1, -1, nacked, t);
    nk = K_PTR; ex = t + 1;

    // Randomized run: random data, stalls, NACKs and mux changes
    for (int it = 0; it < 24; it++) begin
      int n, na;
      rr = 16'($urandom);
      case (nk)
        K_CFG:   begin set_cfg(m_mux); n = 6; na = int'($urandom_range(1, 4)); end
        K_PTR:   begin set_ptr();      n = 4; na = int'($urandom_range(1, 2)); end
        default: begin set_rd();       n = 5; na = 1; end
      endcase
      if ($urandom_range(0, 3) != 0) na = -1;
      run_txn($sformatf("rnd%0d", it), n, na, rr, ex, -1, -1, nacked, t);
      if (nacked) begin
        chk("nack_sample_hold", 32'(sample), 32'(m_sample));
        nk = K_CFG; ex = t + BACKOFF + 1;
      end else if (nk == K_CFG) begin
        nk = K_PTR; ex = t + 1;
      end else if (nk == K_PTR) begin
        nk = K_RD; ex = t + CONV_WAIT + 1;
      end else begin
        rd_done(rr);
        if ($urandom_range(0, 3) == 0) begin
          mux_change(ex);
          nk = K_CFG;
        end else begin
          ex = t + CONV_WAIT + 1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ads_seq_ctrl.md
Name: ads_seq_ctrl

Overview:
Transaction sequencer for the ADS1115 I2C path. It configures the ADC in continuous-conversion mode and sets the pointer register. It then periodically reads the 16-bit conversion result and presents it as a sample. It issues byte-level commands to the downstream I2C byte engine, which is clocked alongside the SCL divider, and consumes that engine's per-command responses.

Parameters:
I2C_ADDR, 7'h48, 7-bit ADS1115 slave address
PGA, 3'b001, PGA field of config-hi byte (±4.096 V)
CFG_LO, 8'h83, config-lo byte (DR=128 SPS, comparator disabled)
CONV_WAIT, 400000, clk cycles between conversion reads (8 ms at 50 MHz)
BACKOFF, 50000, clk cycles idle after an error before retry

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
enable  in  1  run sequencer; low = finish current transaction, then idle
cfg_mux  in  3  ADS1115 MUX field; a change forces reconfiguration
cmd_valid  out  1  command presented to I2C byte engine
cmd_ready  in  1  engine accepts command
cmd_op  out  3  0=START 1=WRITE 2=READ_ACK 3=READ_NACK 4=STOP
cmd_data  out  8  byte for WRITE; 0 otherwise
rsp_valid  in  1  one-cycle pulse, exactly one per accepted command
rsp_nack  in  1  slave NACKed (valid with rsp_valid on WRITE)
rsp_data  in  8  read byte (valid with rsp_valid on READ_*)
sample  out  16  last conversion result {msb,lsb}
sample_valid  out  1  one-cycle pulse when sample updates
busy  out  1  high in any state except IDLE
err  out  1  sticky; set on NACK, cleared on next sample_valid
err_cnt  out  8  NACK/abort count, saturates at 255

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; latched mux 0.
- Handshake: transfer when cmd_valid&&cmd_ready. cmd_op and cmd_data are held stable while cmd_valid&&!cmd_ready. After a transfer, cmd_valid drops next cycle. The next command waits for the matching rsp_valid, so exactly one command is outstanding. rsp_valid with nothing outstanding is ignored.
- States:
  - IDLE: enable=1 → CFG.
  - CFG: mux latched on entry. Sequence: START, WRITE {I2C_ADDR,0}, WRITE 8'h01, WRITE {1'b1,mux,PGA,1'b0}, WRITE CFG_LO, STOP. Then → PTR.
  - PTR: START, WRITE {I2C_ADDR,0}, WRITE 8'h00, STOP. Then → WAIT.
  - WAIT: counts CONV_WAIT cycles, then → RD. cfg_mux ≠ latched mux → CFG immediately (counter cleared). enable=0 → IDLE.
  - RD: START, WRITE {I2C_ADDR,1}, READ_ACK (msb), READ_NACK (lsb), STOP. On the STOP response: sample={msb,lsb}, sample_valid=1 for one cycle, err=0, → WAIT (or IDLE if enable=0).
  - ERR: issue STOP, wait for its response → BACKOFF.
  - BACKOFF: count BACKOFF cycles → CFG (IDLE if enable=0).
- NACK: rsp_nack on any WRITE response → err=1, err_cnt+1 (saturating), → ERR. The remaining bytes of that transaction are not issued.
- enable deasserted mid-transaction: the transaction completes through its STOP; no new START is issued; → IDLE.
- sample holds its value across errors and idle; updates only on a complete RD.
- Counter widths: ceil(log2(max(CONV_WAIT,BACKOFF)+1)) bits; terminal count is compared for equality, with no wrap.
- Reset asserted mid-operation: cmd_valid drops asynchronously; the engine is responsible for bus recovery.

Optional Feature:
ADS_SEQ_RSP_TIMEOUT_EN:
- Defined: adds parameter RSP_TIMEOUT (default 65535) and a watchdog counting cycles from command acceptance to rsp_valid. Expiry is treated as a NACK: err=1, err_cnt+1, → ERR. If the timed-out command was STOP (in ERR), go straight to BACKOFF.
- Undefined: no watchdog; the sequencer waits indefinitely for rsp_valid.

Test Plan:
- Reset low, enable=1, cfg_mux=3'b100, responder always ACKs → CFG command stream START, 0x90, 0x01, 0xC2, 0x83, STOP; then PTR START, 0x90, 0x00, STOP.
- Continue; responder returns 0x12, 0x34 on reads → RD bytes 0x91, READ_ACK, READ_NACK, STOP; sample=16'h1234, one-cycle sample_valid. Next RD START occurs CONV_WAIT cycles after the previous STOP response.
- NACK on the 0x90 WRITE of CFG → STOP issued next, err=1, err_cnt=1; CFG restarts after BACKOFF cycles; the next good sample clears err.
- Change cfg_mux 3'b100→3'b101 during WAIT → immediate CFG with config-hi 0xD2; no RD issued before it.
- Hold cmd_ready=0 for 10 cycles on a WRITE → cmd_op/cmd_data stable and cmd_valid high throughout. enable=0 mid-RD → RD completes through STOP, then IDLE, busy=0.
- With ADS_SEQ_RSP_TIMEOUT_EN and RSP_TIMEOUT=100, withhold rsp_valid → at cycle 100, err=1, err_cnt+1, STOP issued.
